// File: rtl/hamming_secded_stream_if.sv
// Streaming bundle for the SECDED codec: input beat side (valid/ready/mode/data)
// and output beat side (valid/ready/mode/data/syndrome/flags).
// The codec sits on the slave modport; whoever feeds and drains it uses master.
interface hamming_secded_stream_if #(
    parameter int K = 8
);
    localparam int R = (K <= 4) ? 3 : ((K <= 11) ? 4 : 5);
    localparam int N = K + R + 1;

    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_mode;
    logic [N-1:0] out_data;
    logic [R-1:0] out_syndrome;
    logic         out_err_corr;
    logic         out_err_uncorr;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, out_syndrome,
               out_err_corr, out_err_uncorr
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, out_syndrome,
               out_err_corr, out_err_uncorr
    );
endinterface

// File: rtl/hamming_secded_stream.sv
// Two-stage streaming Hamming SECDED encoder/decoder with per-beat mode select
// and saturating corrected/uncorrectable error counters.
// Codeword: bit 0 is overall parity, bits 1..K+R use the classic Hamming layout
// with parity at power-of-two positions and data filling the rest in order.
module hamming_secded_stream #(
    parameter int K     = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    hamming_secded_stream_if.slave bus,
    input  logic                  cnt_clear_i,
    output logic [CNT_W-1:0]      corr_count_o,
    output logic [CNT_W-1:0]      uncorr_count_o
);
    localparam int R = (K <= 4) ? 3 : ((K <= 11) ? 4 : 5);
    localparam int N = K + R + 1;
    localparam int M = K + R;

    // Place data bits into the non-power-of-two positions, ascending.
    function automatic logic [N-1:0] scatterData(input logic [K-1:0] d);
        logic [N-1:0] w;
        int           j;
        w = '0;
        j = 0;
        for (int p = 1; p <= M; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p] = d[j];
                j++;
            end
        end
        return w;
    endfunction

    // Pull data bits back out of the non-power-of-two positions.
    function automatic logic [K-1:0] gatherData(input logic [N-1:0] w);
        logic [K-1:0] d;
        int           j;
        d = '0;
        j = 0;
        for (int p = 1; p <= M; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = w[p];
                j++;
            end
        end
        return d;
    endfunction

    // XOR of the indices of all set bits in positions 1..M. On a data-only
    // word this is exactly the set of Hamming parity bits to insert.
    function automatic logic [R-1:0] syndromeOf(input logic [N-1:0] w);
        logic [R-1:0] s;
        s = '0;
        for (int p = 1; p <= M; p++) begin
            if (w[p]) s = s ^ R'(p);
        end
        return s;
    endfunction

    logic         advance;
    logic         s1Valid_q;
    logic         s1Mode_q;
    logic [N-1:0] s1Word_q;
    logic [R-1:0] s1Syn_q;
    logic         s1Par_q;
    logic [N-1:0] s1Word_d;
    logic [R-1:0] s1Syn_d;
    logic         s1Par_d;

    logic         outValid_q;
    logic         outMode_q;
    logic [N-1:0] outData_q;
    logic [R-1:0] outSyn_q;
    logic         outCorr_q;
    logic         outUncorr_q;
    logic [N-1:0] outData_d;
    logic [R-1:0] outSyn_d;
    logic         outCorr_d;
    logic         outUncorr_d;
    logic [N-1:0] encWord;
    logic [N-1:0] fixedWord;

    logic [CNT_W-1:0] corrCount_q;
    logic [CNT_W-1:0] uncorrCount_q;
    logic             outXfer;

    assign advance      = !outValid_q | bus.out_ready;
    assign bus.in_ready = advance;

    // Stage 1 front end: encode scatters data, decode keeps the received word.
    always_comb begin
        s1Word_d = bus.in_mode ? bus.in_data : scatterData(bus.in_data[K-1:0]);
        s1Syn_d  = syndromeOf(s1Word_d);
        s1Par_d  = ^s1Word_d;
    end

    // Stage 1 register: captures a beat only on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Mode_q  <= 1'b0;
            s1Word_q  <= '0;
            s1Syn_q   <= '0;
            s1Par_q   <= 1'b0;
        end else if (advance) begin
            s1Valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1Mode_q <= bus.in_mode;
                s1Word_q <= s1Word_d;
                s1Syn_q  <= s1Syn_d;
                s1Par_q  <= s1Par_d;
            end
        end
    end

    // Stage 2 back end: finish the codeword, or classify/correct and extract data.
    always_comb begin
        outData_d   = '0;
        outSyn_d    = '0;
        outCorr_d   = 1'b0;
        outUncorr_d = 1'b0;
        encWord     = s1Word_q;
        fixedWord   = s1Word_q;
        for (int i = 0; i < R; i++) begin
            encWord[1 << i] = s1Syn_q[i];
        end
        if (!s1Mode_q) begin
            outData_d = {encWord[N-1:1], ^encWord[N-1:1]};
        end else begin
            outSyn_d = s1Syn_q;
            if (s1Par_q) begin
                if (int'(s1Syn_q) <= M) begin
                    fixedWord[s1Syn_q] = ~fixedWord[s1Syn_q];
                    outCorr_d          = 1'b1;
                end else begin
                    outUncorr_d = 1'b1;
                end
            end else if (s1Syn_q != '0) begin
                outUncorr_d = 1'b1;
            end
            outData_d = {{(N-K){1'b0}}, gatherData(fixedWord)};
        end
    end

    // Stage 2 register: output beat holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            outMode_q   <= 1'b0;
            outData_q   <= '0;
            outSyn_q    <= '0;
            outCorr_q   <= 1'b0;
            outUncorr_q <= 1'b0;
        end else if (advance) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outMode_q   <= s1Mode_q;
                outData_q   <= outData_d;
                outSyn_q    <= outSyn_d;
                outCorr_q   <= outCorr_d;
                outUncorr_q <= outUncorr_d;
            end
        end
    end

    assign outXfer = outValid_q & bus.out_ready & outMode_q;

    // Saturating error counters, bumped when a flagged decode beat leaves; clear wins.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear_i) begin
            corrCount_q   <= '0;
            uncorrCount_q <= '0;
        end else begin
            if (outXfer && outCorr_q && (corrCount_q != '1)) begin
                corrCount_q <= corrCount_q + 1'b1;
            end
            if (outXfer && outUncorr_q && (uncorrCount_q != '1)) begin
                uncorrCount_q <= uncorrCount_q + 1'b1;
            end
        end
    end

    assign bus.out_valid      = outValid_q;
    assign bus.out_mode       = outMode_q;
    assign bus.out_data       = outData_q;
    assign bus.out_syndrome   = outSyn_q;
    assign bus.out_err_corr   = outCorr_q;
    assign bus.out_err_uncorr = outUncorr_q;
    assign corr_count_o       = corrCount_q;
    assign uncorr_count_o     = uncorrCount_q;
endmodule

// File: tb/tb_hamming_secded_stream.sv
// Directed bench for the streaming SECDED codec (K=8). A second instance with
// 2-bit counters runs in lockstep so counter saturation can be observed.
module tb_hamming_secded_stream;
    localparam int K = 8;

    typedef struct {
        logic        mode;
        logic [12:0] data;
        logic [3:0]  syn;
        logic        corr;
        logic        uncorr;
        logic        chkLat;
        int          acc;
    } item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cntClear;
    logic [7:0] corr1;
    logic [7:0] uncorr1;
    logic [1:0] corr2;
    logic [1:0] uncorr2;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    item_t sb[$];
    item_t popped;
    int    mCorr1 = 0;
    int    mUncorr1 = 0;
    int    mCorr2 = 0;
    int    mUncorr2 = 0;
    logic  stallPrev = 1'b0;
    logic [19:0] snap;
    logic  incC;
    logic  incU;

    hamming_secded_stream_if #(.K(K)) bus0 ();
    hamming_secded_stream_if #(.K(K)) bus1 ();

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_mode   = bus0.in_mode;
    assign bus1.in_data   = bus0.in_data;
    assign bus1.out_ready = bus0.out_ready;

    hamming_secded_stream #(.K(K), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus0.slave), .cnt_clear_i(cntClear),
        .corr_count_o(corr1), .uncorr_count_o(uncorr1)
    );

    hamming_secded_stream #(.K(K), .CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .bus(bus1.slave), .cnt_clear_i(cntClear),
        .corr_count_o(corr2), .uncorr_count_o(uncorr2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Codeword position of data bit j for K=8.
    function automatic int dataPos(input int j);
        case (j)
            0: return 3;
            1: return 5;
            2: return 6;
            3: return 7;
            4: return 9;
            5: return 10;
            6: return 11;
            default: return 12;
        endcase
    endfunction

    function automatic logic [12:0] modelEncode(input logic [7:0] d);
        logic [12:0] w;
        logic        pb;
        w = '0;
        for (int j = 0; j < 8; j++) w[dataPos(j)] = d[j];
        for (int i = 0; i < 4; i++) begin
            pb = 1'b0;
            for (int p = 1; p <= 12; p++) begin
                if ((p & (1 << i)) != 0) pb = pb ^ w[p];
            end
            w[1 << i] = pb;
        end
        w[0] = ^w[12:1];
        return w;
    endfunction

    function automatic item_t mkItem(input logic mode, input logic [12:0] data,
                                     input logic [3:0] syn, input logic corr,
                                     input logic uncorr, input logic chkLat);
        item_t it;
        it.mode = mode; it.data = data; it.syn = syn;
        it.corr = corr; it.uncorr = uncorr; it.chkLat = chkLat; it.acc = 0;
        return it;
    endfunction

    function automatic item_t modelDecode(input logic [12:0] w, input logic chkLat);
        logic [3:0]  s;
        logic        par;
        logic [12:0] fw;
        logic [7:0]  d;
        logic        c;
        logic        u;
        s = '0;
        for (int p = 1; p <= 12; p++) if (w[p]) s = s ^ 4'(p);
        par = ^w;
        fw = w; c = 1'b0; u = 1'b0;
        if (par && s <= 4'd12) begin
            fw[s] = ~fw[s];
            c = 1'b1;
        end else if (par || s != 4'd0) begin
            u = 1'b1;
        end
        for (int j = 0; j < 8; j++) d[j] = fw[dataPos(j)];
        return mkItem(1'b1, {5'b0, d}, s, c, u, chkLat);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat, wait (bounded) for acceptance, record its expected result.
    task automatic applyStimulus(input logic mode, input logic [12:0] din, input item_t exp);
        int    guard;
        item_t e;
        e = exp;
        bus0.in_valid = 1'b1;
        bus0.in_mode  = mode;
        bus0.in_data  = din;
        guard = 0;
        @(negedge clk);
        while (bus0.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept_in_time", 32'(guard < 50), 32'd1);
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: counter model checks, stall hold checks, scoreboard pops.
    always @(negedge clk) begin
        checkOutput("corr_count", 32'(corr1), 32'(mCorr1));
        checkOutput("uncorr_count", 32'(uncorr1), 32'(mUncorr1));
        checkOutput("corr_count_sat", 32'(corr2), 32'(mCorr2));
        checkOutput("uncorr_count_sat", 32'(uncorr2), 32'(mUncorr2));
        if (stallPrev) begin
            checkOutput("hold_valid", 32'(bus0.out_valid), 32'd1);
            checkOutput("hold_bus", 32'({bus0.out_mode, bus0.out_data, bus0.out_syndrome,
                        bus0.out_err_corr, bus0.out_err_uncorr}), 32'(snap));
        end
        stallPrev = 1'b0;
        incC = 1'b0;
        incU = 1'b0;
        if (rst !== 1'b1) begin
            if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b0) begin
                checkOutput("stall_in_ready", 32'(bus0.in_ready), 32'd0);
                snap = {bus0.out_mode, bus0.out_data, bus0.out_syndrome,
                        bus0.out_err_corr, bus0.out_err_uncorr};
                stallPrev = 1'b1;
            end
            if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
                checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    popped = sb.pop_front();
                    checkOutput("out_mode", 32'(bus0.out_mode), 32'(popped.mode));
                    checkOutput("out_data", 32'(bus0.out_data), 32'(popped.data));
                    checkOutput("out_syndrome", 32'(bus0.out_syndrome), 32'(popped.syn));
                    checkOutput("out_err_corr", 32'(bus0.out_err_corr), 32'(popped.corr));
                    checkOutput("out_err_uncorr", 32'(bus0.out_err_uncorr), 32'(popped.uncorr));
                    if (popped.chkLat) checkOutput("latency", 32'(cyc - popped.acc), 32'd2);
                    incC = popped.mode & popped.corr;
                    incU = popped.mode & popped.uncorr;
                end
            end
        end
        if (rst === 1'b1 || cntClear === 1'b1) begin
            mCorr1 = 0; mUncorr1 = 0; mCorr2 = 0; mUncorr2 = 0;
        end else begin
            if (incC && mCorr1 < 255) mCorr1++;
            if (incU && mUncorr1 < 255) mUncorr1++;
            if (incC && mCorr2 < 3) mCorr2++;
            if (incU && mUncorr2 < 3) mUncorr2++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [4:0]  up;
        logic [12:0] cw;
        int          b1;
        int          b2;
        item_t       it;

        rst = 1'b1;
        cntClear = 1'b0;
        bus0.in_valid = 1'b0;
        bus0.in_mode = 1'b0;
        bus0.in_data = '0;
        bus0.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", 32'(bus0.out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(bus0.in_ready), 32'd1);
        checkOutput("reset_out_data", 32'(bus0.out_data), 32'd0);
        checkOutput("reset_flags", 32'({bus0.out_syndrome, bus0.out_err_corr, bus0.out_err_uncorr}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back encodes with hand-derived codewords.
        applyStimulus(1'b0, 13'h0001, mkItem(1'b0, 13'h000F, 4'd0, 1'b0, 1'b0, 1'b1));
        applyStimulus(1'b0, 13'h00FF, mkItem(1'b0, 13'h1EEE, 4'd0, 1'b0, 1'b0, 1'b1));
        // Decodes: single error, parity-bit error, double error, clean.
        applyStimulus(1'b1, 13'h002F, mkItem(1'b1, 13'h0001, 4'd5, 1'b1, 1'b0, 1'b1));
        applyStimulus(1'b1, 13'h000E, mkItem(1'b1, 13'h0001, 4'd0, 1'b1, 1'b0, 1'b1));
        applyStimulus(1'b1, 13'h003F, mkItem(1'b1, 13'h0003, 4'd1, 1'b0, 1'b1, 1'b1));
        applyStimulus(1'b1, 13'h1EEE, mkItem(1'b1, 13'h00FF, 4'd0, 1'b0, 1'b0, 1'b1));
        waitDrain();
        checkOutput("corr_after_decodes", 32'(corr1), 32'd2);
        checkOutput("uncorr_after_decodes", 32'(uncorr1), 32'd1);
        @(posedge clk);
        #1;

        // Boundaries: syndrome past the last position, and error in the last position.
        applyStimulus(1'b1, 13'h1003, mkItem(1'b1, 13'h0080, 4'd13, 1'b0, 1'b1, 1'b1));
        applyStimulus(1'b1, 13'h1000, mkItem(1'b1, 13'h0000, 4'd12, 1'b1, 1'b0, 1'b1));
        waitDrain();
        @(posedge clk);
        #1;

        // Alternating encode/decode stream with the consumer stalled mid-way.
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    d = 8'($urandom_range(0, 255));
                    if (k % 2 == 0) begin
                        up = 5'($urandom_range(0, 31));
                        applyStimulus(1'b0, {up, d},
                                      mkItem(1'b0, modelEncode(d), 4'd0, 1'b0, 1'b0, 1'b0));
                    end else begin
                        cw = modelEncode(d);
                        b1 = $urandom_range(0, 12);
                        b2 = (b1 + 1 + $urandom_range(0, 11)) % 13;
                        if (k == 3) cw[b1] = ~cw[b1];
                        if (k == 5) begin
                            cw[b1] = ~cw[b1];
                            cw[b2] = ~cw[b2];
                        end
                        applyStimulus(1'b1, cw, modelDecode(cw, 1'b0));
                    end
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                bus0.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                bus0.out_ready = 1'b1;
            end
        join
        waitDrain();
        @(posedge clk);
        #1;

        // Five corrected beats drive the 2-bit counter into saturation.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 13'h002F, mkItem(1'b1, 13'h0001, 4'd5, 1'b1, 1'b0, 1'b1));
        end
        waitDrain();
        checkOutput("corr_saturated", 32'(corr2), 32'd3);
        @(posedge clk);
        #1;

        // Clear coincident with a corrected output transfer.
        applyStimulus(1'b1, 13'h002F, mkItem(1'b1, 13'h0001, 4'd5, 1'b1, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        cntClear = 1'b1;
        @(posedge clk);
        #1;
        cntClear = 1'b0;
        @(negedge clk);
        checkOutput("clear_corr", 32'(corr1), 32'd0);
        checkOutput("clear_corr_sat", 32'(corr2), 32'd0);
        checkOutput("clear_uncorr", 32'(uncorr1), 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 13'h003F, mkItem(1'b1, 13'h0003, 4'd1, 1'b0, 1'b1, 1'b1));
        waitDrain();
        checkOutput("uncorr_after_clear", 32'(uncorr1), 32'd1);
        @(posedge clk);
        #1;

        // Reset with two beats in flight: both are discarded.
        applyStimulus(1'b1, 13'h002F, mkItem(1'b1, 13'h0001, 4'd5, 1'b1, 1'b0, 1'b1));
        applyStimulus(1'b1, 13'h003F, mkItem(1'b1, 13'h0003, 4'd1, 1'b0, 1'b1, 1'b1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("midreset_out_valid", 32'(bus0.out_valid), 32'd0);
        checkOutput("midreset_corr", 32'(corr1), 32'd0);
        checkOutput("midreset_uncorr", 32'(uncorr1), 32'd0);
        @(posedge clk);
        #1;
        it = mkItem(1'b0, modelEncode(8'hA5), 4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 13'h00A5, it);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hamming_secded_stream.md
Name: hamming_secded_stream

Overview:
- Parametrised, streaming Hamming SECDED (single-error-correct, double-error-detect) codec.
- Successor to the fixed-width Hamming encode/decode top.
- Per-beat mode select (encode or decode), valid/ready handshake on both sides, 2-stage pipeline.
- Saturating corrected/uncorrectable error counters for the chip-level status readout.

Parameters:
- K, 8, data bits per word (legal 4..26).
- CNT_W, 8, width of each error counter.
- R (localparam), smallest r with 2^r >= K+r+1; 4 for K=8.
- N (localparam), K+R+1 codeword bits; 13 for K=8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_mode  in  1  0=encode, 1=decode
- in_data  in  N  encode: data in [K-1:0], upper bits ignored; decode: received codeword
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_mode  out  1  mode of output beat
- out_data  out  N  encode: codeword; decode: corrected data in [K-1:0], upper bits 0
- out_syndrome  out  R  decode syndrome; 0 in encode mode
- out_err_corr  out  1  decode, single error corrected
- out_err_uncorr  out  1  decode, uncorrectable error detected
- cnt_clear  in  1  synchronous clear of both counters
- corr_count  out  CNT_W  saturating count of corrected beats
- uncorr_count  out  CNT_W  saturating count of uncorrectable beats

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all outputs 0 (out_valid=0, counters=0). in_ready=1 from the first cycle after reset.
- Reset asserted mid-stream discards both pipeline stages. No output beat is produced for discarded beats.
- Codeword layout:
  - Bit 0 is the overall parity bit.
  - Bits 1..K+R follow the standard Hamming layout: parity bits at power-of-2 positions.
  - Data bits d0..d(K-1) fill the remaining positions in ascending order.
  - Parity bit at position 2^i = XOR of all positions p in 1..K+R with bit i of p set.
  - Bit 0 = XOR of bits 1..K+R, giving even parity over all N bits.
- Decode:
  - s = XOR of indices of set bits in 1..K+R, R bits wide.
  - p = XOR of all N bits.
  - s=0, p=0: clean. Both flags 0.
  - p=1, s<=K+R: single error at position s (s=0 means bit 0 is in error). Flip that bit, set err_corr.
  - p=0, s!=0: double error. Set err_uncorr; data extracted uncorrected.
  - p=1, s>K+R: invalid position. Set err_uncorr; no flip.
  - err_corr and err_uncorr are never both 1.
- Pipeline and handshake:
  - Stage 1 registers mode and computes s/p (decode) or the parity bits (encode).
  - Stage 2 registers the final outputs.
  - Latency is 2 cycles from accepted input to out_valid with no backpressure.
  - Throughput is 1 beat/cycle.
  - advance = !out_valid | out_ready. in_ready = advance. Both stages move only when advance=1.
  - Input transfer occurs when in_valid & in_ready.
  - Stage bubbles propagate as out_valid=0.
  - While out_valid=1 and out_ready=0, every out_* signal holds stable.
  - Beats never dropped, duplicated or reordered.
  - in_data sampled only on transfer.
- Counters:
  - Increment on output transfer (out_valid & out_ready) of a decode beat with the matching flag.
  - Saturate at 2^CNT_W-1.
  - cnt_clear has priority over an increment in the same cycle; counters read 0 next cycle.
  - Counter updates do not affect the data path.

Test Plan:
- K=8, encode 0x01 then 0xFF, out_ready=1 → out_data 0x000F then 0x1EEE, both 2 cycles after input, back-to-back. Syndrome 0, flags 0.
- Decode 0x002F (0x000F with bit 5 flipped) → out_data 0x01, syndrome 5, err_corr=1, corr_count=1. Decode 0x000E (bit 0 flipped) → data 0x01, syndrome 0, err_corr=1.
- Decode 0x003F (bits 4,5 flipped) → syndrome 1, err_uncorr=1, err_corr=0, uncorr_count=1. Decode 0x1EEE → data 0xFF, flags 0.
- Stream 6 alternating encode/decode beats with out_ready held low cycles 3-6 → in_ready=0 while stalled, out_* stable, all 6 results emerge in order with no loss.
- CNT_W=2, 5 corrected beats → corr_count saturates at 3. cnt_clear coincident with a corrected transfer → corr_count 0 next cycle.
- rst asserted one cycle while 2 beats are in flight → out_valid=0 and counters 0 the next cycle; the next beat accepted produces its result 2 cycles later.
